// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA display geometry, RGB444 colours, bar table and pattern modes
package vga_pkg;
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_RED    = 12'hF00;
  localparam logic [11:0] RGB_GREEN  = 12'h0F0;
  localparam logic [11:0] RGB_BLUE   = 12'h00F;
  localparam logic [11:0] RGB_YELLOW = 12'hFF0;
  localparam logic [11:0] RGB_WHITE  = 12'hFFF;
  localparam logic [11:0] BAR_COLORS [5] = '{RGB_RED, RGB_GREEN, RGB_BLUE, RGB_YELLOW, RGB_WHITE};
  typedef enum logic [1:0] {
    MODE_SOLID    = 2'b00,
    MODE_BARS     = 2'b01,
    MODE_BOX      = 2'b10,
    MODE_BOX_BARS = 2'b11
  } mode_t;
  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    return idx < 3'd5 ? BAR_COLORS[idx] : RGB_BLACK;
  endfunction
endpackage

// File: rtl/box_mover.sv
// box_mover: per-frame box position with bounce off the display walls
module box_mover
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [10:0] box_x,
  output logic [10:0] box_y
);
  localparam logic [10:0] X_MAX = 11'(H_DISPLAY - BOX_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_DISPLAY - BOX_SIZE);
  localparam logic [10:0] DELTA = 11'(BOX_STEP);
  logic right, down, hit_x, hit_y;
  logic [10:0] nx, ny;
  // a move that lands on or crosses the far wall parks the box on it and turns it around
  always_comb begin
    hit_x = right ? box_x + DELTA >= X_MAX : box_x < DELTA;
    hit_y = down ? box_y + DELTA >= Y_MAX : box_y < DELTA;
    nx = hit_x ? (right ? X_MAX : '0) : right ? box_x + DELTA : box_x - DELTA;
    ny = hit_y ? (down ? Y_MAX : '0) : down ? box_y + DELTA : box_y - DELTA;
  end
  // position and direction change only on the once-per-frame step
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      box_x <= '0;
      box_y <= '0;
      right <= 1'b1;
      down  <= 1'b1;
    end else if (step) begin
      box_x <= nx;
      box_y <= ny;
      right <= right ^ hit_x;
      down  <= down ^ hit_y;
    end
endmodule

// File: rtl/pixel_gen.sv
// pixel_gen: two-stage VGA test-pattern pipeline; moving box built only with PIXEL_GEN_BOX_EN
module pixel_gen
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        video_on,
  input  logic [9:0]  pixelx,
  input  logic [9:0]  pixely,
  input  logic [1:0]  mode,
  input  logic [11:0] color,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync
);
  logic [9:0] x1, y1;
  logic v1, hs1, vs1;
  mode_t m1;
  logic [11:0] bar, pix;
  assign bar = bar_color(x1[9:7]);
`ifdef PIXEL_GEN_BOX_EN
  logic [10:0] box_x, box_y;
  logic in_box;
  box_mover #(.BOX_SIZE(BOX_SIZE), .BOX_STEP(BOX_STEP)) u_box_mover (
    .clk,
    .reset,
    .step(tick && pixely == 10'(V_DISPLAY) && pixelx == '0),
    .box_x,
    .box_y
  );
  assign in_box = {1'b0, x1} >= box_x && {1'b0, x1} < box_x + 11'(BOX_SIZE) &&
                  {1'b0, y1} >= box_y && {1'b0, y1} < box_y + 11'(BOX_SIZE);
  assign pix = !v1 ? RGB_BLACK : m1 == MODE_SOLID ? color : m1 == MODE_BARS ? bar :
               in_box ? color : m1 == MODE_BOX ? RGB_BLACK : bar;
`else
  logic unused_box;
  assign unused_box = ^{y1, x1[6:0], BOX_SIZE[0], BOX_STEP[0]};
  assign pix = !v1 ? RGB_BLACK : m1 == MODE_SOLID ? color : bar;
`endif
  // stage 1: capture pixel context on each tick
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x1  <= '0;
      y1  <= '0;
      v1  <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      m1  <= MODE_SOLID;
    end else if (tick) begin
      x1  <= pixelx;
      y1  <= pixely;
      v1  <= video_on;
      hs1 <= hsync_in;
      vs1 <= vsync_in;
      m1  <= mode_t'(mode);
    end
  // stage 2: registered colour with syncs kept aligned to it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (tick) begin
      rgb   <= pix;
      hsync <= hs1;
      vsync <= vs1;
    end
endmodule

// File: tb/tb_pixel_gen.sv
// tb_pixel_gen: randomized self-checking bench for pixel_gen and box_mover
module tb_pixel_gen;
  logic clk = 0, reset = 0, tick = 0, hsync_in = 0, vsync_in = 0, video_on = 0;
  logic [9:0] pixelx = 0, pixely = 0;
  logic [1:0] mode = 0;
  logic [11:0] color = 12'hF00;
  logic [11:0] rgb;
  logic hsync, vsync;
  logic mv_step = 0;
  logic [10:0] mv_x, mv_y;
  int passed = 0, total = 0;
  logic [11:0] bars [5] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hFFF};
  logic [13:0] prev_exp = 0;
  string prev_name = "reset";
  int bx = 0, by = 0, mx = 0, my = 0;
  bit brx = 1, bry = 1, mrx = 1, mry = 1;

  always #5 clk = ~clk;

  pixel_gen #(.BOX_SIZE(32), .BOX_STEP(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .video_on(video_on), .pixelx(pixelx), .pixely(pixely), .mode(mode), .color(color),
    .rgb(rgb), .hsync(hsync), .vsync(vsync)
  );

  box_mover #(.BOX_SIZE(32), .BOX_STEP(2)) u_mv (
    .clk(clk), .reset(reset), .step(mv_step), .box_x(mv_x), .box_y(mv_y)
  );

  task automatic advance(inout int p, inout bit fwd, input int lim);
    p = p + (fwd ? 2 : -2);
    if (fwd && p >= lim) begin
      p = lim;
      fwd = 0;
    end else if (!fwd && p < 0) begin
      p = 0;
      fwd = 1;
    end
  endtask

  function automatic logic [11:0] model_rgb(input int x, input int y, input bit v,
                                            input logic [1:0] m, input logic [11:0] c);
    bit box_en, in_box;
`ifdef PIXEL_GEN_BOX_EN
    box_en = 1;
`else
    box_en = 0;
`endif
    in_box = x >= bx && x < bx + 32 && y >= by && y < by + 32;
    if (!v) return 12'h000;
    if (m == 2'd0) return c;
    if (box_en && m[1] && in_box) return c;
    if (box_en && m == 2'd2) return 12'h000;
    return x < 640 ? bars[x / 128] : 12'h000;
  endfunction

  task automatic reset_models();
    prev_exp = 0;
    prev_name = "after reset";
    bx = 0; by = 0; brx = 1; bry = 1;
    mx = 0; my = 0; mrx = 1; mry = 1;
  endtask

  task automatic send(input int x, input int y, input bit v, input bit hs, input bit vs,
                      input int gap, input string nm);
    logic [13:0] e;
    pixelx = 10'(x); pixely = 10'(y); video_on = v; hsync_in = hs; vsync_in = vs; tick = 1;
    if (x == 0 && y == 480) begin
      advance(bx, brx, 608);
      advance(by, bry, 448);
    end
    e = {model_rgb(x, y, v, mode, color), hs, vs};
    @(negedge clk);
    tick = 0;
    total++;
    if ({rgb, hsync, vsync} !== prev_exp)
      $display("FAIL %s: rgb/hsync/vsync=%h/%b/%b expected %h/%b/%b", prev_name,
               rgb, hsync, vsync, prev_exp[13:2], prev_exp[1], prev_exp[0]);
    else passed++;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      total++;
      if ({rgb, hsync, vsync} !== prev_exp)
        $display("FAIL hold %s: rgb/hsync/vsync=%h/%b/%b expected %h/%b/%b", prev_name,
                 rgb, hsync, vsync, prev_exp[13:2], prev_exp[1], prev_exp[0]);
      else passed++;
    end
    prev_exp = e;
    prev_name = nm;
  endtask

  task automatic mv_pulse(input string nm);
    @(negedge clk);
    mv_step = 1;
    advance(mx, mrx, 608);
    advance(my, mry, 448);
    @(negedge clk);
    mv_step = 0;
    total++;
    if (mv_x !== 11'(mx) || mv_y !== 11'(my))
      $display("FAIL %s: box=(%0d,%0d) expected (%0d,%0d)", nm, mv_x, mv_y, mx, my);
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0; tick = 0; mv_step = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    reset_models();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tick = 1; video_on = 1; hsync_in = 1; vsync_in = 1; mv_step = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({rgb, hsync, vsync} !== 14'd0)
      $display("FAIL reset outputs: rgb/hsync/vsync=%h/%b/%b expected 000/0/0", rgb, hsync, vsync);
    else passed++;
    total++;
    if (mv_x !== 11'd0 || mv_y !== 11'd0)
      $display("FAIL reset box: box=(%0d,%0d) expected (0,0)", mv_x, mv_y);
    else passed++;
    tick = 0; mv_step = 0; video_on = 0; hsync_in = 0; vsync_in = 0;
    reset = 1;
    reset_models();
  endtask

  task automatic test_latency();
    mode = 2'd0;
    for (int i = 0; i < 12; i++)
      send($urandom_range(639), $urandom_range(479), 1, 1'($urandom), 1'($urandom), 3, "latency");
    send(10, 10, 0, 0, 0, 3, "latency blank");
  endtask

  task automatic test_bars();
    color = 12'h5A3;
    mode = 2'd1;
    send(127, 20, 1, 0, 0, 0, "bar0 x=127");
    send(128, 20, 1, 1, 0, 0, "bar1 x=128");
    send(300, 20, 0, 0, 1, 0, "bars blanked");
    for (int i = 0; i < 16; i++)
      send($urandom_range(639), $urandom_range(479), 1'($urandom_range(3) != 0),
           1'($urandom), 1'($urandom), 0, "bars random");
    send(0, 0, 0, 0, 0, 0, "bars flush");
  endtask

  task automatic test_mode_alias();
    for (int i = 0; i < 16; i++) begin
      mode = 2'($urandom_range(3));
      send($urandom_range(639), $urandom_range(479), 1, 1'($urandom), 1'($urandom), 0, "mode alias");
    end
    mode = 2'd3;
    send(639, 479, 1, 0, 0, 0, "mode 11 last bar");
    send(0, 0, 0, 0, 0, 0, "mode alias flush");
  endtask

`ifdef PIXEL_GEN_BOX_EN
  task automatic test_box();
    do_reset();
    mode = 2'd2;
    for (int f = 0; f < 3; f++) send(0, 480, 0, 0, 1, 1, "frame tick");
    send(6, 6, 1, 0, 0, 0, "box corner 6,6");
    send(5, 6, 1, 0, 0, 0, "left of box 5,6");
    send(37, 37, 1, 0, 0, 0, "box corner 37,37");
    send(38, 6, 1, 0, 0, 0, "right of box 38,6");
    for (int i = 0; i < 12; i++) begin
      mode = 2'($urandom_range(2, 3));
      send($urandom_range(50), $urandom_range(50), 1, 0, 0, 0, "box random");
    end
    send(0, 0, 0, 0, 0, 0, "box flush");
    total++;
    if (rgb !== 12'h000)
      $display("FAIL box flush: rgb=%h expected 000", rgb);
    else passed++;
  endtask
`endif

  task automatic test_mover();
    do_reset();
    for (int i = 1; i <= 306; i++) begin
      mv_pulse("mover frame");
      if (i == 3) begin
        total++;
        if (mv_x !== 11'd6 || mv_y !== 11'd6)
          $display("FAIL mover 3 frames: box=(%0d,%0d) expected (6,6)", mv_x, mv_y);
        else passed++;
      end
      if (i == 303 || i == 305) begin
        total++;
        if (mv_x !== 11'd606)
          $display("FAIL mover bounce frame %0d: box_x=%0d expected 606", i, mv_x);
        else passed++;
      end
      if (i == 304) begin
        total++;
        if (mv_x !== 11'd608)
          $display("FAIL mover wall frame: box_x=%0d expected 608", mv_x);
        else passed++;
      end
    end
    @(negedge clk);
    total++;
    if (mv_x !== 11'(mx) || mv_y !== 11'(my))
      $display("FAIL mover hold: box=(%0d,%0d) expected (%0d,%0d)", mv_x, mv_y, mx, my);
    else passed++;
  endtask

  task automatic test_midframe_reset();
    mode = 2'd0;
    color = 12'hF00;
    mv_pulse("pre-reset mover");
    mv_pulse("pre-reset mover");
    for (int i = 0; i < 4; i++)
      send($urandom_range(639), $urandom_range(479), 1, 1, 1, 0, "pre-reset");
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    total++;
    if ({rgb, hsync, vsync} !== 14'd0)
      $display("FAIL mid-frame reset outputs: rgb/hsync/vsync=%h/%b/%b expected 000/0/0", rgb, hsync, vsync);
    else passed++;
    total++;
    if (mv_x !== 11'd0 || mv_y !== 11'd0)
      $display("FAIL mid-frame reset box: box=(%0d,%0d) expected (0,0)", mv_x, mv_y);
    else passed++;
    tick = 1;
    repeat (3) @(negedge clk);
    reset = 1;
    tick = 0;
    reset_models();
    send(100, 100, 1, 1, 1, 0, "post-release first");
    send(200, 100, 1, 0, 0, 0, "post-release second");
    send(300, 100, 0, 0, 0, 0, "post-release flush");
    mv_pulse("post-reset mover");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bars();
    test_mode_alias();
`ifdef PIXEL_GEN_BOX_EN
    test_box();
`endif
    test_mover();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
